// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field layout, calendar constants and BCD helpers
// for the calendar-date counter.
package rtc_pkg;

   localparam int DAY_LSB  = 0;
   localparam int MON_LSB  = 8;
   localparam int YEAR_LSB = 16;

   localparam int V_DAY  = 0;
   localparam int V_MON  = 1;
   localparam int V_YEAR = 2;

   localparam logic [7:0] FEB = 8'h02;
   localparam logic [7:0] APR = 8'h04;
   localparam logic [7:0] JUN = 8'h06;
   localparam logic [7:0] SEP = 8'h09;
   localparam logic [7:0] NOV = 8'h11;
   localparam logic [7:0] DEC = 8'h12;

   localparam logic [7:0] DIM_28 = 8'h28;
   localparam logic [7:0] DIM_29 = 8'h29;
   localparam logic [7:0] DIM_30 = 8'h30;
   localparam logic [7:0] DIM_31 = 8'h31;

   typedef struct packed {
      logic [15:0] year;
      logic [7:0]  mon;
      logic [7:0]  day;
   } date_t;

   function automatic logic [3:0] dig_inc(
      input logic [3:0] d,
      input logic       nine
   );
      return nine ? 4'h0 : d + 4'h1;
   endfunction

   function automatic logic [7:0] bcd_inc(
      input logic [7:0] b,
      input logic       nine
   );
      logic [3:0] tens;
      tens = nine ? b[7:4] + 4'h1 : b[7:4];
      return {tens, dig_inc(b[3:0], nine)};
   endfunction

endpackage

// File: rtl/rtcdate_last_day.sv
// rtcdate_last_day: last BCD day of a month, given the leap-year flag.
// Months outside 01..12 fall through to 31 days.
module rtcdate_last_day
   import rtc_pkg::*;
(
   input  logic [7:0] month_i,
   input  logic       leap_i,
   output logic [7:0] last_day_o
);

   always_comb begin
      last_day_o = DIM_31;
      case (month_i)
         APR, JUN, SEP, NOV: last_day_o = DIM_30;
         FEB:                last_day_o = leap_i ? DIM_29 : DIM_28;
         default:            last_day_o = DIM_31;
      endcase
   end

endmodule

// File: rtl/rtcdate.sv
// rtcdate: BCD calendar-date counter advanced by the once-per-day strobe.
// A free-running two-stage pipeline precomputes the next date.
module rtcdate
   import rtc_pkg::*;
#(
   parameter logic [31:0] INITIAL_DATE = 32'h2000_01_01,
   parameter int unsigned SETTLE       = 3
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_ppd,
   input  logic        i_wr,
   input  logic [31:0] i_data,
   input  logic [2:0]  i_valid,
   output logic [31:0] o_data,
   output logic        o_ppy
);

   localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

   function automatic logic div4(input logic [7:0] b);
      if (b[4]) return (b[3:0] == 4'h2) || (b[3:0] == 4'h6);
      return (b[3:0] == 4'h0) || (b[3:0] == 4'h4) ||
             (b[3:0] == 4'h8);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      return div4(y[7:0]) &&
             ((y[7:0] != 8'h00) || div4(y[15:8]));
   endfunction

   function automatic logic [15:0] year_inc(
      input logic [15:0] y,
      input logic [3:0]  nine
   );
      logic [15:0] r;
      logic        run;
      r   = y;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (run) r[4*i +: 4] = dig_inc(y[4*i +: 4], nine[i]);
         run = run & nine[i];
      end
      return r;
   endfunction

   date_t         date_q, date_d;
   date_t         next_q, next_d;
   logic          ppy_q, ppy_d;
   logic [SW-1:0] settle_q, settle_d;

   logic          day_last_q, day_last_d;
   logic          mon_last_q, mon_last_d;
   logic          leap_q, leap_d;
   logic          day_cy_q, day_cy_d;
   logic          mon_cy_q, mon_cy_d;
   logic [3:0]    yr_cy_q, yr_cy_d;

   logic [7:0]    last_day;
   logic          wr_en;
   logic          unused_bits;

   // Leap is taken from its register: the year only changes on 01/01,
   // and after writes/reset the settle window covers the extra cycle.
   rtcdate_last_day u_last_day (
      .month_i    (date_q.mon),
      .leap_i     (leap_q),
      .last_day_o (last_day)
   );

   always_comb begin
      leap_d     = is_leap(date_q.year);
      day_last_d = date_q.day >= last_day;
      mon_last_d = date_q.mon >= DEC;
      day_cy_d   = date_q.day[3:0] == 4'h9;
      mon_cy_d   = date_q.mon[3:0] == 4'h9;
      for (int i = 0; i < 4; i++) begin
         yr_cy_d[i] = date_q.year[4*i +: 4] == 4'h9;
      end
   end

   always_comb begin
      next_d = date_q;
      if (!day_last_q) begin
         next_d.day = bcd_inc(date_q.day, day_cy_q);
      end else begin
         next_d.day = 8'h01;
         if (!mon_last_q) begin
            next_d.mon = bcd_inc(date_q.mon, mon_cy_q);
         end else begin
            next_d.mon  = 8'h01;
            next_d.year = year_inc(date_q.year, yr_cy_q);
         end
      end
   end

   assign wr_en = i_wr && (i_valid != 3'b000);

   always_comb begin
      date_d   = date_q;
      ppy_d    = 1'b0;
      settle_d = settle_q;
      if (wr_en) begin
         if (i_valid[V_DAY]) begin
            date_d.day = {2'b00, i_data[DAY_LSB +: 6]};
         end
         if (i_valid[V_MON]) begin
            date_d.mon = {3'b000, i_data[MON_LSB +: 5]};
         end
         if (i_valid[V_YEAR]) begin
            date_d.year = i_data[YEAR_LSB +: 16];
         end
         settle_d = SETTLE_V;
      end else if (settle_q != '0) begin
         settle_d = settle_q - SW'(1);
      end else if (i_ppd) begin
         date_d = next_q;
         ppy_d  = day_last_q && mon_last_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         date_q     <= date_t'(INITIAL_DATE);
         ppy_q      <= 1'b0;
         settle_q   <= SETTLE_V;
         next_q     <= '0;
         day_last_q <= 1'b0;
         mon_last_q <= 1'b0;
         leap_q     <= 1'b0;
         day_cy_q   <= 1'b0;
         mon_cy_q   <= 1'b0;
         yr_cy_q    <= '0;
      end else begin
         date_q     <= date_d;
         ppy_q      <= ppy_d;
         settle_q   <= settle_d;
         next_q     <= next_d;
         day_last_q <= day_last_d;
         mon_last_q <= mon_last_d;
         leap_q     <= leap_d;
         day_cy_q   <= day_cy_d;
         mon_cy_q   <= mon_cy_d;
         yr_cy_q    <= yr_cy_d;
      end
   end

   assign o_data      = date_q;
   assign o_ppy       = ppy_q;
   assign unused_bits = ^{i_data[15:13], i_data[7:6]};

endmodule

// File: tb/tb_rtcdate.sv
// tb_rtcdate: scoreboard bench for rtcdate, checked every cycle
// against a plain-integer Gregorian calendar model.
module tb_rtcdate;

   localparam logic [31:0] INIT   = 32'h2000_01_01;
   localparam int          SETTLE = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ppd;
   logic        wr;
   logic [31:0] wdata;
   logic [2:0]  valid;
   logic [31:0] o_data;
   logic        o_ppy;

   always #5 clk = ~clk;

   rtcdate #(
      .INITIAL_DATE (INIT),
      .SETTLE       (SETTLE)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_ppd     (ppd),
      .i_wr      (wr),
      .i_data    (wdata),
      .i_valid   (valid),
      .o_data    (o_data),
      .o_ppy     (o_ppy)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   string       phase  = "init";
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   int          my, mm, md, mset;
   bit          mppy;

   int          kind, ry, rm, rd;
   logic [2:0]  rv;

   function automatic int bcd2i(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] i2b8(input int v);
      logic [3:0] t, u;
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   function automatic logic [15:0] i2b16(input int v);
      return {i2b8(v / 100), i2b8(v % 100)};
   endfunction

   function automatic logic [31:0] bdate(input int y, input int m, input int d);
      return {i2b16(y), i2b8(m), i2b8(d)};
   endfunction

   function automatic int dim(input int m, input int y);
      bit lp;
      lp = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
      case (m)
         2:            return lp ? 29 : 28;
         4, 6, 9, 11:  return 30;
         default:      return 31;
      endcase
   endfunction

   task automatic model_step(input bit r, input bit p, input bit w,
                             input logic [31:0] d, input logic [2:0] v);
      mppy = 1'b0;
      if (r) begin
         my   = bcd2i(INIT[31:24]) * 100 + bcd2i(INIT[23:16]);
         mm   = bcd2i(INIT[15:8]);
         md   = bcd2i(INIT[7:0]);
         mset = SETTLE;
      end else if (w && v != 3'b000) begin
         if (v[0]) md = bcd2i(d[7:0]);
         if (v[1]) mm = bcd2i(d[15:8]);
         if (v[2]) my = bcd2i(d[31:24]) * 100 + bcd2i(d[23:16]);
         mset = SETTLE;
      end else if (mset > 0) begin
         mset--;
      end else if (p) begin
         if (md < dim(mm, my)) begin
            md++;
         end else begin
            md = 1;
            if (mm < 12) begin
               mm++;
            end else begin
               mm   = 1;
               my   = (my + 1) % 10000;
               mppy = 1'b1;
            end
         end
      end
   endtask

   task automatic cyc(input bit r, input bit p, input bit w,
                      input logic [31:0] d, input logic [2:0] v);
      @(negedge clk);
      rst_n = ~r;
      ppd   = p;
      wr    = w;
      wdata = d;
      valid = v;
      model_step(r, p, w, d, v);
      exp_q.push_back({bdate(my, mm, md), mppy});
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
   endtask

   task automatic wr_date(input logic [31:0] d, input logic [2:0] v);
      cyc(1'b0, 1'b0, 1'b1, d, v);
   endtask

   task automatic pulse();
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 3'b000);
   endtask

   task automatic chk_now(input string name, input logic [31:0] want);
      @(posedge clk);
      #2;
      n_chk++;
      if (o_data === want) n_pass++;
      else $display("FAIL %s: o_data=%h expected %h", name, o_data, want);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_chk++;
         if ({o_data, o_ppy} === mon_e) n_pass++;
         else $display("FAIL sb[%s] t=%0t: data=%h ppy=%b expected data=%h ppy=%b",
                       phase, $time, o_data, o_ppy, mon_e[32:1], mon_e[0]);
      end
   end

   initial begin
      rst_n = 1'b0;
      ppd   = 1'b0;
      wr    = 1'b0;
      wdata = 32'h0;
      valid = 3'b000;

      phase = "reset";
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
      idle(3);
      pulse();
      chk_now("reset_adv", 32'h2000_0102);
      idle(16);

      phase = "leap2024";
      wr_date(32'h2024_0228, 3'b111);
      idle(5);
      pulse();
      chk_now("feb28_leap", 32'h2024_0229);
      idle(16);
      pulse();
      chk_now("feb29_roll", 32'h2024_0301);
      idle(16);

      phase = "century";
      wr_date(32'h2100_0228, 3'b111);
      idle(5);
      pulse();
      chk_now("y2100_noleap", 32'h2100_0301);
      idle(16);
      wr_date(32'h2000_0228, 3'b111);
      idle(5);
      pulse();
      chk_now("y2000_leap", 32'h2000_0229);
      idle(16);

      phase = "yearwrap";
      wr_date(32'h9999_1231, 3'b111);
      idle(5);
      pulse();
      chk_now("y9999_wrap", 32'h0000_0101);
      idle(16);

      phase = "wr_vs_ppd";
      wr_date(32'h2023_0430, 3'b111);
      idle(5);
      cyc(1'b0, 1'b1, 1'b1, 32'h1999_0000, 3'b100);
      chk_now("write_beats_adv", 32'h1999_0430);
      idle(1);
      pulse();
      chk_now("ppd_dropped", 32'h1999_0430);
      idle(9);
      pulse();
      chk_now("after_settle", 32'h1999_0501);
      idle(16);

      phase = "odd_writes";
      wr_date(32'h2023_0230, 3'b111);
      idle(5);
      pulse();
      chk_now("feb30_fwd", 32'h2023_0301);
      idle(16);
      wr_date(32'h2023_0031, 3'b111);
      idle(5);
      pulse();
      chk_now("month00", 32'h2023_0101);
      idle(16);
      cyc(1'b0, 1'b0, 1'b1, 32'h1111_1111, 3'b000);
      pulse();
      chk_now("valid0_ignored", 32'h2023_0102);
      idle(16);

      phase = "day_only";
      wr_date(32'h2023_0615, 3'b111);
      idle(5);
      wr_date(32'h0000_0009, 3'b001);
      idle(5);
      pulse();
      chk_now("day09_carry", 32'h2023_0610);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
      chk_now("midrun_reset", 32'h2000_0101);
      idle(16);

      phase = "random";
      for (int k = 0; k < 80; k++) begin
         kind = $urandom_range(0, 5);
         case ($urandom_range(0, 3))
            0:       ry = $urandom_range(0, 9999);
            1:       ry = 2000;
            2:       ry = 1900;
            default: ry = 9999;
         endcase
         rm = $urandom_range(0, 12);
         rd = $urandom_range(0, 1) ? 28 + $urandom_range(0, 3)
                                   : $urandom_range(0, 31);
         rv = 3'($urandom_range(0, 7));
         case (kind)
            3:       wr_date(bdate(ry, rm, rd), rv);
            4:       cyc(1'b0, 1'b1, 1'b1, bdate(ry, rm, rd), rv);
            default: pulse();
         endcase
         idle($urandom_range(16, 30));
      end

      idle(2);
      @(posedge clk);
      #3;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL sb_drain: %0d entries left expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rtcdate.md
Name: rtcdate

Overview:
- BCD calendar-date counter, directly downstream of the time-of-day counter.
- Consumes its once-per-day strobe (asserted on the last clock of 23:59:59) and advances a 0xYYYYMMDD BCD date.
- Handles per-month lengths, Gregorian leap years and year rollover.
- Supports partial software writes of day, month and year from the bus wrapper.

Parameters:
- INITIAL_DATE, 32'h2000_01_01, date loaded on reset.
- SETTLE, 3, clocks after a write during which day-advance is inhibited while next-date logic reconverges (must be >= 3).

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  synchronous active-low reset.
- i_ppd  input  1  once-per-day strobe, single-cycle; strobes are >= 16 clocks apart.
- i_wr  input  1  write request.
- i_data  input  32  write data, {year[31:16], month[15:8], day[7:0]}, BCD.
- i_valid  input  3  field enables: [0] day, [1] month, [2] year.
- o_data  output  32  current date, 0xYYYYMMDD BCD; month[15:13] and day[7:6] always 0.
- o_ppy  output  1  one-cycle pulse, the cycle the date becomes 01/01 by advance.

Behaviour:
- Interface: one clock, i_clk. Reset is synchronous and active-low, i_reset_n; all state updates on posedge i_clk.
- Reset (i_reset_n==0 at posedge):
  - o_data <= INITIAL_DATE, o_ppy <= 0.
  - Settle counter <= SETTLE, so advance is inhibited after reset.
  - Pipeline flags <= 0.
- Next-date pipeline, free-running, two register stages:
  - Stage 1 registers:
    - day_last: day >= days-in-month(month, leap).
    - mon_last: month >= 0x12.
    - leap: year is a Gregorian leap year.
    - day/month/year digit carries: units digit == 9.
  - Stage 2 registers next_date from the current date and stage-1 flags.
  - Result is valid 2 clocks after o_data last changed.
- Days-in-month: 0x31, or 0x30 for months 04/06/09/11, Feb 0x28 or 0x29 when leap.
  - The >= compare means an out-of-range written day (e.g. 02/30) advances to 03/01 rather than counting on.
- Leap rule, BCD:
  - Let yy = year[7:0], cc = year[15:8].
  - A byte is "div4" if (tens even AND units in {0,4,8}) OR (tens odd AND units in {2,6}).
  - leap = div4(yy) AND (yy != 0x00 OR div4(cc)).
- Advance, on a cycle with i_ppd high and settle counter == 0:
  - If !day_last: day += 1 in BCD (units 9 -> 0 with tens +1).
  - If day_last and !mon_last: day <= 0x01, month += 1 in BCD (0x09 -> 0x10).
  - If day_last and mon_last: day <= 0x01, month <= 0x01, year += 1 in BCD across 4 digits; 0x9999 wraps to 0x0000. o_ppy <= 1 in the same register update.
  - o_data updates 1 clock after i_ppd.
- Write, i_wr && |i_valid:
  - Each enabled field is loaded from i_data; disabled fields are held.
  - Write beats an advance in the same cycle: all fields are held except the written ones, and no o_ppy.
  - Settle counter <= SETTLE.
- Settle counter:
  - Decrements to 0 when nonzero and no write.
  - i_ppd arriving while the counter is nonzero is dropped entirely.
- i_wr with i_valid==0 is ignored and does not reload the settle counter.
- o_ppy is 0 in every cycle other than a year-rollover advance.
- Month 0x00 written: treated as not last; advances to 0x01 at the next day_last.
- Reset mid-pipeline: flags are cleared; inhibit covers reconvergence.

Decomposition:
- Shared package rtc_pkg:
  - BCD field offsets (DAY_LSB=0, MON_LSB=8, YEAR_LSB=16).
  - Month constants (FEB=8'h02, DEC=8'h12).
  - Days-in-month constants (8'h28, 8'h29, 8'h30, 8'h31).
  - Valid-bit indices.
- One natural sub-module, rtcdate_last_day: purely combinational month+leap -> last-day BCD.
- Everything else, including the leap function, stays in rtcdate.

Test Plan:
- Reset, then 3 idle clocks, then i_ppd -> o_data 0x2000_01_02; o_ppy stays 0.
- Write 0x2024_02_28 (valid=7), wait 5, i_ppd -> 0x2024_02_29; next i_ppd -> 0x2024_03_01.
- Write 0x2100_02_28, wait 5, i_ppd -> 0x2100_03_01 (century, not leap). Repeat with 0x2000_02_28 -> 0x2000_02_29.
- Write 0x9999_12_31, wait 5, i_ppd -> 0x0000_01_01 with o_ppy=1 for exactly 1 clock.
- Date 0x2023_04_30: i_ppd and write valid=3'b100 data 0x1999xxxx in the same cycle -> 0x1999_04_30. A second i_ppd 2 clocks later is dropped. i_ppd 10 clocks later -> 0x1999_05_01.
- Write day 0x09 valid=001 onto 0x2023_06_xx, wait 5, i_ppd -> 0x2023_06_10. i_reset_n low one clock -> 0x2000_01_01.
